issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/Public_Info.sv | 12 +
 rtl/issue_queue_pkg.sv | 13 +
 rtl/issue_queue_if.sv | 34 +++
 rtl/issue_queue.sv | 109 ++++++++++
 tb/tb_issue_queue.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/Public_Info.sv
// Project-wide shared types: the decoded-instruction record passed between
// pipeline stages and the default issue queue depth.
package Public_Info;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] inst;
  } PC_set;

endpackage

// File: rtl/issue_queue_pkg.sv
// Issue-queue local definitions: decode of the two-bit push enable into a
// push mode.
package issue_queue_pkg;

  // i_in_valid encoding: [1] = older slot (i_set1), [0] = younger slot (i_set2).
  typedef enum logic [1:0] {
    PUSH_NONE = 2'b00,
    PUSH_SET2 = 2'b01,
    PUSH_SET1 = 2'b10,
    PUSH_BOTH = 2'b11
  } push_mode_e;

endpackage

// File: rtl/issue_queue_if.sv
// Decode-to-dispatch bundle around the issue queue. Decode (master) presents
// up to two instructions per cycle; dispatch reads the two oldest entries.
interface issue_queue_if
  import Public_Info::*;
#(
  parameter int DEPTH = IQ_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a push in i_in_valid is taken on the edge only when o_stall
  // was low before that edge; otherwise it is dropped and decode must hold it.
  // i_usingNUM entries leave the head on the same edge (clamped to o_count).
  logic          i_flush;
  PC_set         i_set1;
  PC_set         i_set2;
  logic [1:0]    i_in_valid;
  logic [1:0]    i_usingNUM;
  PC_set         o_set1;
  PC_set         o_set2;
  logic [1:0]    o_is_valid;
  logic          o_stall;
  logic [CW-1:0] o_count;

  modport master (
    output i_flush, i_set1, i_set2, i_in_valid, i_usingNUM,
    input  o_set1, o_set2, o_is_valid, o_stall, o_count
  );

  modport slave (
    input  i_flush, i_set1, i_set2, i_in_valid, i_usingNUM,
    output o_set1, o_set2, o_is_valid, o_stall, o_count
  );

endinterface

// File: rtl/issue_queue.sv
// Circular instruction buffer between decode and dispatch: two-wide compacted
// push, up to count-limited pop, flush and storage-free validity via count.
module issue_queue
  import Public_Info::*;
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  issue_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  PC_set mem_q [DEPTH];
  ptr_t  head_q, head_d;
  ptr_t  tail_q, tail_d;
  cnt_t  count_q, count_d;

  logic  stall;
  logic  accept;
  cnt_t  npush;
  cnt_t  npop;
  logic  wr0_en, wr1_en;
  ptr_t  wr0_idx, wr1_idx;
  PC_set wr0_data;

  // Stall looks only at registered occupancy so decode never sees a
  // combinational path from dispatch's consumption.
  assign stall          = (count_q >= cnt_t'(DEPTH - 1));
  assign bus.o_stall    = stall;
  assign bus.o_count    = count_q;
  assign bus.o_is_valid = {count_q != '0, count_q >= cnt_t'(2)};
  assign bus.o_set1     = mem_q[head_q];
  assign bus.o_set2     = mem_q[head_q + ptr_t'(1)];

  always_comb begin
    accept   = !stall && !bus.i_flush;
    npush    = '0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_idx  = tail_q;
    wr1_idx  = tail_q + ptr_t'(1);
    wr0_data = bus.i_set1;

    // A lone younger instruction goes straight to the tail: no holes.
    if (accept) begin
      case (push_mode_e'(bus.i_in_valid))
        PUSH_BOTH: begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
          npush  = cnt_t'(2);
        end
        PUSH_SET1: begin
          wr0_en = 1'b1;
          npush  = cnt_t'(1);
        end
        PUSH_SET2: begin
          wr0_en   = 1'b1;
          wr0_data = bus.i_set2;
          npush    = cnt_t'(1);
        end
        default: ;
      endcase
    end

    npop    = (cnt_t'(bus.i_usingNUM) > count_q) ? count_q : cnt_t'(bus.i_usingNUM);
    head_d  = head_q + ptr_t'(npop);
    tail_d  = tail_q + ptr_t'(npush);
    count_d = count_q + npush - npop;
    if (count_d > cnt_t'(DEPTH)) begin
      count_d = cnt_t'(DEPTH);
    end

    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[wr0_idx] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[wr1_idx] <= bus.i_set2;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed corner sequences followed by random traffic,
// all checked against a queue-based model of the buffer contents.
module tb_issue_queue;
  import Public_Info::*;

  localparam int DEPTH = 8;
  localparam int W     = $bits(PC_set);

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  issue_queue_if #(.DEPTH(DEPTH)) bus ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("count", W'(bus.o_count), W'(n));
    check("valid", W'(bus.o_is_valid), W'({n >= 1, n >= 2}));
    check("stall", W'(bus.o_stall), W'((DEPTH - n) < 2));
    if (n >= 1) check("set1", bus.o_set1, exp_q[0]);
    if (n >= 2) check("set2", bus.o_set2, exp_q[1]);
  endtask

  // driver: present one cycle of inputs, advance the model at the edge, check after it
  task automatic step(input logic r, input logic f, input logic [1:0] v, input logic [1:0] u,
                      input logic [W-1:0] s1, input logic [W-1:0] s2);
    int n;
    int npop;
    bit can_push;
    rst            = r;
    bus.i_flush    = f;
    bus.i_in_valid = v;
    bus.i_usingNUM = u;
    bus.i_set1     = PC_set'(s1);
    bus.i_set2     = PC_set'(s2);
    @(posedge clk);
    n        = exp_q.size();
    can_push = (DEPTH - n) >= 2;
    if (r || f) begin
      exp_q.delete();
    end else begin
      npop = (int'(u) > n) ? n : int'(u);
      repeat (npop) void'(exp_q.pop_front());
      if (can_push) begin
        if (v[1]) exp_q.push_back(s1);
        if (v[0]) exp_q.push_back(s2);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'b00, 2'b00, rnd(), rnd());
  endtask

  initial begin
    logic [W-1:0] a, b, c, d, e;
    rst            = 1'b1;
    bus.i_flush    = 1'b0;
    bus.i_in_valid = 2'b00;
    bus.i_usingNUM = 2'b00;
    bus.i_set1     = '0;
    bus.i_set2     = '0;

    // reset with pending push must leave the queue empty
    step(1'b1, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    do_reset();
    check("rst_count", W'(bus.o_count), W'(0));
    check("rst_valid", W'(bus.o_is_valid), W'(2'b00));
    check("rst_stall", W'(bus.o_stall), W'(0));

    // fill: 2,4,6,8 then dropped pushes
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    check("fill_count", W'(bus.o_count), W'(8));
    check("fill_stall", W'(bus.o_stall), W'(1));
    step(1'b0, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    step(1'b0, 1'b0, 2'b10, 2'b00, rnd(), rnd());
    check("fill_drop", W'(bus.o_count), W'(8));
    step(1'b0, 1'b0, 2'b01, 2'b01, rnd(), rnd());
    check("drain_one", W'(bus.o_count), W'(7));
    check("stall_at7", W'(bus.o_stall), W'(1));

    // compaction
    do_reset();
    step(1'b0, 1'b0, 2'b01, 2'b00, rnd(), {32'h1c000000, 32'h00000013});
    step(1'b0, 1'b0, 2'b10, 2'b00, {32'h1c000004, 32'h00000013}, rnd());
    check("cmp_pc1", W'(bus.o_set1.PC), W'(32'h1c000000));
    check("cmp_pc2", W'(bus.o_set2.PC), W'(32'h1c000004));
    check("cmp_valid", W'(bus.o_is_valid), W'(2'b11));

    // simultaneous push and pop
    do_reset();
    a = rnd(); b = rnd(); c = rnd(); d = rnd(); e = rnd();
    step(1'b0, 1'b0, 2'b11, 2'b00, a, b);
    step(1'b0, 1'b0, 2'b10, 2'b00, c, rnd());
    step(1'b0, 1'b0, 2'b11, 2'b10, d, e);
    check("sim_count", W'(bus.o_count), W'(3));
    check("sim_set1", bus.o_set1, c);
    check("sim_set2", bus.o_set2, d);

    // over-pop
    do_reset();
    step(1'b0, 1'b0, 2'b10, 2'b00, rnd(), rnd());
    step(1'b0, 1'b0, 2'b00, 2'b10, rnd(), rnd());
    check("ovp_count", W'(bus.o_count), W'(0));
    check("ovp_valid", W'(bus.o_is_valid), W'(2'b00));
    step(1'b0, 1'b0, 2'b10, 2'b11, a, rnd());
    check("ovp_after", bus.o_set1, a);

    // wrap: empty with head=tail=7, then a 2-wide push
    do_reset();
    step(1'b0, 1'b0, 2'b10, 2'b00, rnd(), rnd());
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'b10, 2'b01, rnd(), rnd());
    step(1'b0, 1'b0, 2'b00, 2'b01, rnd(), rnd());
    check("wrap_empty", W'(bus.o_count), W'(0));
    a = rnd(); b = rnd();
    step(1'b0, 1'b0, 2'b11, 2'b00, a, b);
    check("wrap_pc1", W'(bus.o_set1.PC), W'(a[W-1 -: 32]));
    check("wrap_pc2", W'(bus.o_set2.PC), W'(b[W-1 -: 32]));

    // flush with push, then rst with push
    do_reset();
    step(1'b0, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    step(1'b0, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    step(1'b0, 1'b0, 2'b10, 2'b00, rnd(), rnd());
    check("fl_count5", W'(bus.o_count), W'(5));
    step(1'b0, 1'b1, 2'b11, 2'b01, rnd(), rnd());
    check("fl_count", W'(bus.o_count), W'(0));
    check("fl_valid", W'(bus.o_is_valid), W'(2'b00));
    step(1'b0, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    step(1'b0, 1'b0, 2'b11, 2'b00, rnd(), rnd());
    step(1'b1, 1'b0, 2'b11, 2'b01, rnd(), rnd());
    check("rs_count", W'(bus.o_count), W'(0));
    check("rs_stall", W'(bus.o_stall), W'(0));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd(), rnd());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
